// File: rtl/ptw_walk_sched_pkg.sv
// Shared MMU walk-scheduler definitions: state encoding, walker handshake
// structs and the response-pulse decode used by the scheduler FSM.
package ptw_walk_sched_pkg;

  localparam int VALEN_DEF      = 32;
  localparam int STARVE_MAX_DEF = 4;
  localparam int STARVE_W       = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_DRAIN = 3'd4
  } type_walk_sched_state_e;

  typedef struct packed {
    logic                 req;
    logic [VALEN_DEF-1:0] vaddr;
    logic                 is_instr;
    logic                 is_store;
  } type_sched2ptw_s;

  typedef struct packed {
    logic ack;
    logic done;
    logic error;
  } type_ptw2sched_s;

  // Packed as {itlb_update, dtlb_update, i_page_fault, d_page_fault}.
  function automatic logic [3:0] resp_pulse(input logic is_instr, input logic error);
    logic [3:0] p;
    p = 4'b0000;
    case ({is_instr, error})
      2'b10:   p = 4'b1000;
      2'b00:   p = 4'b0100;
      2'b11:   p = 4'b0010;
      default: p = 4'b0001;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/ptw_walk_sched_arb.sv
// ITLB/DTLB grant selection with a saturating starvation counter that
// forces an ITLB grant after STARVE_MAX consecutive DTLB wins.
module ptw_grant_arb
  import ptw_walk_sched_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic itlb_miss,
  input  logic dtlb_miss,
  input  logic grant_en,
  output logic grant_instr
);

  localparam logic [STARVE_W-1:0] CNT_MAX = STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] starve_cnt;

  // DTLB is the older instruction and wins ties until the ITLB has waited long enough.
  assign grant_instr = itlb_miss && (!dtlb_miss || (starve_cnt == CNT_MAX));

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (grant_en) begin
      if (grant_instr || !itlb_miss) begin
        starve_cnt <= '0;
      end else if (starve_cnt != CNT_MAX) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ptw_walk_sched.sv
// Page-table-walk scheduler: arbitrates ITLB/DTLB misses onto one walker,
// tracks the walk and returns a single update/fault pulse to the owner.
module ptw_walk_sched
  import ptw_walk_sched_pkg::*;
#(
  parameter int VALEN      = VALEN_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             itlb_miss_i,
  input  logic [VALEN-1:0] itlb_vaddr_i,
  input  logic             dtlb_miss_i,
  input  logic [VALEN-1:0] dtlb_vaddr_i,
  input  logic             dtlb_is_store_i,
  input  logic             flush_i,
  output logic             walk_req_o,
  output logic [VALEN-1:0] walk_vaddr_o,
  output logic             walk_is_instr_o,
  output logic             walk_is_store_o,
  input  logic             walk_ack_i,
  input  logic             walk_done_i,
  input  logic             walk_error_i,
  output logic             itlb_update_o,
  output logic             dtlb_update_o,
  output logic             i_page_fault_o,
  output logic             d_page_fault_o,
  output logic             busy_o
);

  localparam logic [2:0] IDLE  = ST_IDLE;
  localparam logic [2:0] REQ   = ST_REQ;
  localparam logic [2:0] WAIT  = ST_WAIT;
  localparam logic [2:0] RESP  = ST_RESP;
  localparam logic [2:0] DRAIN = ST_DRAIN;

  logic [2:0]      state;
  logic [3:0]      pulse_q;
  logic            grant_en;
  logic            grant_instr;
  type_ptw2sched_s ptw_in;

  assign ptw_in = '{ack: walk_ack_i, done: walk_done_i, error: walk_error_i};

  // A miss seen together with a flush belongs to a squashed instruction.
  assign grant_en = (state == IDLE) && !flush_i && (itlb_miss_i || dtlb_miss_i);

  ptw_grant_arb #(
    .STARVE_MAX (STARVE_MAX)
  ) u_arb (
    .clk         (clk),
    .rst         (rst),
    .itlb_miss   (itlb_miss_i),
    .dtlb_miss   (dtlb_miss_i),
    .grant_en    (grant_en),
    .grant_instr (grant_instr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      walk_req_o      <= 1'b0;
      walk_vaddr_o    <= '0;
      walk_is_instr_o <= 1'b0;
      walk_is_store_o <= 1'b0;
      pulse_q         <= 4'b0000;
      busy_o          <= 1'b0;
    end else begin
      pulse_q <= 4'b0000;
      case (state)
        IDLE: begin
          if (grant_en) begin
            state           <= REQ;
            walk_req_o      <= 1'b1;
            busy_o          <= 1'b1;
            walk_vaddr_o    <= grant_instr ? itlb_vaddr_i : dtlb_vaddr_i;
            walk_is_instr_o <= grant_instr;
            walk_is_store_o <= grant_instr ? 1'b0 : dtlb_is_store_i;
          end
        end
        REQ: begin
          // Once acked the walker owns the request, so a flush must drain it.
          if (ptw_in.ack) begin
            walk_req_o <= 1'b0;
            state      <= flush_i ? DRAIN : WAIT;
          end else if (flush_i) begin
            walk_req_o <= 1'b0;
            state      <= IDLE;
            busy_o     <= 1'b0;
          end
        end
        WAIT: begin
          if (flush_i) begin
            state  <= ptw_in.done ? IDLE : DRAIN;
            busy_o <= !ptw_in.done;
          end else if (ptw_in.done) begin
            state   <= RESP;
            pulse_q <= resp_pulse(walk_is_instr_o, ptw_in.error);
          end
        end
        RESP: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        DRAIN: begin
          if (ptw_in.done) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          walk_req_o <= 1'b0;
          busy_o     <= 1'b0;
        end
      endcase
    end
  end

  assign itlb_update_o  = pulse_q[3];
  assign dtlb_update_o  = pulse_q[2];
  assign i_page_fault_o = pulse_q[1];
  assign d_page_fault_o = pulse_q[0];

endmodule
